nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer.sv | 177 +++++++++++++++++
 tb/tb_nibble_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// nibble_packer: gathers 4-bit samples into 32-bit words of eight slots with a count/sequence control word.
// Optional NIBBLE_PACKER_SUM_EN adds a registered reference sum of each emitted word on sum_out.
module nibble_packer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [3:0]  nib_in,
    input  logic        nib_valid,
    input  logic        flush,
    output logic        nib_ready,
    output logic [31:0] data_out,
    output logic [5:0]  mm_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [6:0]  sum_out
);

    typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] asm_q, asm_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  held_q, held_d;
    logic [2:0]  seq_q, seq_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  mm_q, mm_d;
    logic        valid_q, valid_d;

    logic        accept_s;
    logic        complete_s;
    logic        can_load_s;
    logic [2:0]  slot_s;
    logic [2:0]  cnt_m1_s;
    logic [31:0] asm_new_s;
    logic        load_s;
    logic [31:0] load_word_s;
    logic [2:0]  load_cnt_s;

    // Next-state, assembly and output-register load decisions
    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        idx_d       = idx_q;
        held_d      = held_q;
        seq_d       = seq_q;
        data_d      = data_q;
        mm_d        = mm_q;
        valid_d     = valid_q;
        load_s      = 1'b0;
        load_word_s = asm_q;
        load_cnt_s  = held_q;
        asm_new_s   = asm_q;

        // ready_q is only high in FILL, so it doubles as the FILL qualifier
        accept_s   = nib_valid & ready_q;
        complete_s = ready_q & ((accept_s & (idx_q == 3'd7)) |
                                (flush & ((idx_q != 3'd0) | nib_valid)));
        cnt_m1_s   = accept_s ? idx_q : (idx_q - 3'd1);
        can_load_s = ~valid_q | word_ready;
        slot_s     = MSB_FIRST ? (3'd7 - idx_q) : idx_q;

        if (accept_s) begin
            asm_new_s[{slot_s, 2'b00} +: 4] = nib_in;
        end else begin
            asm_new_s = asm_q;
        end

        case (state_q)
            FILL: begin
                if (complete_s) begin
                    idx_d = 3'd0;
                    if (can_load_s) begin
                        load_s      = 1'b1;
                        load_word_s = asm_new_s;
                        load_cnt_s  = cnt_m1_s;
                        asm_d       = 32'd0;
                    end else begin
                        state_d = FULL;
                        asm_d   = asm_new_s;
                        held_d  = cnt_m1_s;
                    end
                end else if (accept_s) begin
                    asm_d = asm_new_s;
                    idx_d = idx_q + 3'd1;
                end else begin
                    asm_d = asm_q;
                end
            end
            FULL: begin
                if (valid_q & word_ready) begin
                    load_s  = 1'b1;
                    asm_d   = 32'd0;
                    state_d = FILL;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (load_s) begin
            data_d  = load_word_s;
            mm_d    = {seq_q, load_cnt_s};
            valid_d = 1'b1;
            seq_d   = seq_q + 3'd1;
        end else if (word_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        ready_d = (state_d == FILL);
    end

    // State, assembly and output registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            ready_q <= 1'b0;
            asm_q   <= 32'd0;
            idx_q   <= 3'd0;
            held_q  <= 3'd0;
            seq_q   <= 3'd0;
            data_q  <= 32'd0;
            mm_q    <= 6'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
            held_q  <= held_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            mm_q    <= mm_d;
            valid_q <= valid_d;
        end
    end

`ifdef NIBBLE_PACKER_SUM_EN
    function automatic logic [6:0] nibble_sum(input logic [31:0] w);
        logic [6:0] acc;
        acc = 7'd0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + {3'b000, w[i*4 +: 4]};
        end
        return acc;
    endfunction

    logic [6:0] sum_q;

    // Sum register loads together with data_out
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 7'd0;
        end else if (load_s) begin
            sum_q <= nibble_sum(load_word_s);
        end else begin
            sum_q <= sum_q;
        end
    end

    assign sum_out = sum_q;
`else
    assign sum_out = 7'd0;
`endif

    assign nib_ready  = ready_q;
    assign data_out   = data_q;
    assign mm_out     = mm_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed and randomised bench for nibble_packer; LSB-first and MSB-first instances share one stimulus stream.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        flush;
    logic        word_ready;

    logic        nib_ready_l, wv_l, nib_ready_m, wv_m;
    logic [31:0] data_l, data_m;
    logic [5:0]  mm_l, mm_m;
    logic [6:0]  sum_l, sum_m;

    typedef struct {
        logic [31:0] lsb;
        logic [31:0] msb;
        logic [5:0]  mm;
        logic [6:0]  sum;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          bubbles;
    int          cur_n = 0;
    int          cur_sum = 0;
    logic [31:0] cur_lsb = 32'd0;
    logic [31:0] cur_msb = 32'd0;
    logic [2:0]  seq = 3'd0;
    logic [31:0] snap_data;
    logic [5:0]  snap_mm;

    always #5 clk = ~clk;

    nibble_packer #(.MSB_FIRST(1'b0)) u_lsb (
        .sysclk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_valid(nib_valid), .flush(flush),
        .nib_ready(nib_ready_l), .data_out(data_l), .mm_out(mm_l), .word_valid(wv_l),
        .word_ready(word_ready), .sum_out(sum_l)
    );

    nibble_packer #(.MSB_FIRST(1'b1)) u_msb (
        .sysclk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_valid(nib_valid), .flush(flush),
        .nib_ready(nib_ready_m), .data_out(data_m), .mm_out(mm_m), .word_valid(wv_m),
        .word_ready(word_ready), .sum_out(sum_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word();
        exp_t e;
        e.lsb = cur_lsb;
        e.msb = cur_msb;
        e.mm  = {seq, 3'(cur_n - 1)};
`ifdef NIBBLE_PACKER_SUM_EN
        e.sum = 7'(cur_sum);
`else
        e.sum = 7'd0;
`endif
        sb.push_back(e);
        seq     = seq + 3'd1;
        cur_n   = 0;
        cur_sum = 0;
        cur_lsb = 32'd0;
        cur_msb = 32'd0;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!nib_ready_l && w < 20) begin
            if (w >= 2) word_ready = 1'b1;
            @(posedge clk); #1;
            w++;
        end
        if (w > 0) bubbles++;
        if (w >= 20) check("ready_timeout", 32'(nib_ready_l), 32'd1);
    endtask

    task automatic send(input logic [3:0] n, input logic fl);
        wait_ready();
        nib_in = n; nib_valid = 1'b1; flush = fl;
        @(posedge clk); #1;
        nib_valid = 1'b0; flush = 1'b0;
        cur_lsb[cur_n*4 +: 4]       = n;
        cur_msb[(7 - cur_n)*4 +: 4] = n;
        cur_sum = cur_sum + int'(n);
        cur_n++;
        if (cur_n == 8 || fl) push_word();
    endtask

    task automatic flush_only();
        wait_ready();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (cur_n > 0) push_word();
    endtask

    // Scoreboard: a handshake seen here completes on the next rising edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && wv_l && word_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(wv_l), 32'd0);
            end else begin
                e = sb.pop_front();
                check("data_lsb", data_l, e.lsb);
                check("data_msb", data_m, e.msb);
                check("mm", 32'(mm_l), 32'(e.mm));
                check("sum", 32'(sum_l), 32'(e.sum));
                check("msb_valid", 32'(wv_m), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; nib_in = 4'd0; nib_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_l, 32'd0);
        check("rst_mm", 32'(mm_l), 32'd0);
        check("rst_valid", 32'(wv_l), 32'd0);
        check("rst_sum", 32'(sum_l), 32'd0);
        check("rst_ready", 32'(nib_ready_l), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_rise", 32'(nib_ready_l), 32'd1);

        // Full word, sustained input
        word_ready = 1'b1;
        bubbles = 0;
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
        check("full_valid", 32'(wv_l), 32'd1);
        check("full_data", data_l, 32'h87654321);
        check("full_data_msb", data_m, 32'h12345678);
        check("full_mm", 32'(mm_l), 32'(6'b000_111));
        check("no_bubbles", 32'(bubbles), 32'd0);
        @(posedge clk); #1;
        check("full_drop", 32'(wv_l), 32'd0);

        // Flush of a two-nibble word
        send(4'hA, 1'b0);
        send(4'h5, 1'b1);
        check("flush_data", data_l, 32'h0000005A);
        check("flush_mm", 32'(mm_l), 32'(6'b001_001));
        @(posedge clk); #1;

        // Empty flush is ignored; sequence continues at 2
        flush_only();
        repeat (2) @(posedge clk);
        #1;
        check("empty_flush", 32'(wv_l), 32'd0);
        send(4'h3, 1'b1);
        check("seq_after_empty", 32'(mm_l), 32'(6'b010_000));
        @(posedge clk); #1;

        // Backpressure: second word parks in FULL
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(4'hF, 1'b0);
        check("bp_ready", 32'(nib_ready_l), 32'd0);
        check("bp_valid", 32'(wv_l), 32'd1);
        check("bp_mm", 32'(mm_l), 32'(6'b011_111));
        snap_data = data_l;
        snap_mm   = mm_l;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stable_data", data_l, snap_data);
        check("bp_stable_mm", 32'(mm_l), 32'(snap_mm));
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", 32'(sb.size()), 32'd0);
        check("bp_valid_low", 32'(wv_l), 32'd0);
        check("bp_ready_back", 32'(nib_ready_l), 32'd1);

        // Asynchronous reset mid-word
        for (int i = 0; i < 3; i++) send(4'(i + 9), 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_data", data_l, 32'd0);
        check("arst_mm", 32'(mm_l), 32'd0);
        check("arst_valid", 32'(wv_l), 32'd0);
        check("arst_ready", 32'(nib_ready_l), 32'd0);
        sb.delete();
        cur_n = 0; cur_sum = 0; cur_lsb = 32'd0; cur_msb = 32'd0; seq = 3'd0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(4'($urandom_range(0, 15)), 1'b0);
        check("post_rst_mm", 32'(mm_l), 32'(6'b000_111));

        // Randomised traffic with random backpressure and flushes
        for (int i = 0; i < 80; i++) begin
            word_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) flush_only();
            else send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 6) == 0));
        end
        word_ready = 1'b1;
        for (int i = 0; i < 40 && (sb.size() != 0 || wv_l); i++) begin
            @(posedge clk); #1;
        end
        check("final_drain", 32'(sb.size()), 32'd0);
        check("final_valid", 32'(wv_l), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
